// File: rtl/idivu_arb.sv
// Round-robin sequencer sharing one go/busy unsigned divider between NREQ requesters.
// Zero divisors are answered without the divider; a hung divider is abandoned after TMO cycles.
module idivu_arb #(
    parameter int NREQ = 2,
    parameter int W    = 8,
    parameter int TMO  = 255,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*2*W-1:0]    dividend_in,
    input  logic [NREQ*W-1:0]      divisor_in,
    output logic [NREQ-1:0]        ack,
    output logic [W-1:0]           res_quot,
    output logic [W-1:0]           res_rem,
    output logic                   res_ovf,
    output logic                   res_err,
    output logic                   div_go,
    output logic [2*W-1:0]         div_dividend,
    output logic [W-1:0]           div_divisor,
    input  logic                   div_busy,
    input  logic [W-1:0]           div_quot,
    input  logic [W-1:0]           div_rem,
    input  logic                   div_ovf,
    output logic [IW-1:0]          grant_idx
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT, DONE} state_t;

    localparam logic [7:0] TLAST = 8'(TMO - 1);

    state_t                    state;
    logic [IW-1:0]             rr;
    logic [7:0]                tcnt;
    logic [NREQ-1:0][2*W-1:0]  dvd_a;
    logic [NREQ-1:0][W-1:0]    dsr_a;
    logic [IW-1:0]             pick;
    logic [IW-1:0]             kk;
    logic                      any;
    int                        k;

    assign dvd_a = dividend_in;
    assign dsr_a = divisor_in;

    // Scan offsets from high to low so the smallest offset from rr wins last.
    always_comb begin
        pick = rr;
        any  = 1'b0;
        k    = 0;
        kk   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(rr) + i;
            if (k >= NREQ) k = k - NREQ;
            kk = IW'(k);
            if (req[kk]) begin
                pick = kk;
                any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= IDLE;
            rr           <= '0;
            tcnt         <= '0;
            ack          <= '0;
            res_quot     <= '0;
            res_rem      <= '0;
            res_ovf      <= 1'b0;
            res_err      <= 1'b0;
            div_go       <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            grant_idx    <= '0;
        end else begin
            div_go <= 1'b0;
            ack    <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant_idx    <= pick;
                        div_dividend <= dvd_a[pick];
                        div_divisor  <= dsr_a[pick];
                        if (dsr_a[pick] == '0) begin
                            res_quot  <= '1;
                            res_rem   <= '0;
                            res_ovf   <= 1'b1;
                            res_err   <= 1'b0;
                            ack[pick] <= 1'b1;
                            state     <= DONE;
                        end else begin
                            div_go <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT1;
                // Divider raises busy a cycle after go, so busy is not trusted here.
                WAIT1: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!div_busy) begin
                        res_quot       <= div_quot;
                        res_rem        <= div_rem;
                        res_ovf        <= div_ovf;
                        res_err        <= 1'b0;
                        ack[grant_idx] <= 1'b1;
                        state          <= DONE;
                    end else if (tcnt == TLAST) begin
                        res_quot       <= '0;
                        res_rem        <= '0;
                        res_ovf        <= 1'b1;
                        res_err        <= 1'b1;
                        ack[grant_idx] <= 1'b1;
                        state          <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    rr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idivu_arb.sv
// Directed bench for idivu_arb: behavioural divider model plus a scoreboard of expected acks.
module tb_idivu_arb;
    localparam int NREQ = 2;
    localparam int W    = 8;
    localparam int TMO  = 16;
    localparam int LAT  = 3;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [1:0]  req = '0;
    logic [31:0] dividend_in = '0;
    logic [15:0] divisor_in = '0;
    logic [1:0]  ack;
    logic [7:0]  res_quot, res_rem;
    logic        res_ovf, res_err, div_go;
    logic [15:0] div_dividend;
    logic [7:0]  div_divisor;
    logic        div_busy = 1'b0;
    logic [7:0]  div_quot = '0, div_rem = '0;
    logic        div_ovf = 1'b0;
    logic [0:0]  grant_idx;
    logic        hang = 1'b0;
    int          mcnt = 0;
    int          go_cnt = 0;
    int          total = 0, bad = 0;

    typedef struct {
        int         idx;
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       err;
    } exp_t;
    exp_t sb[$];

    idivu_arb #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk(clk), .arst(arst), .req(req), .dividend_in(dividend_in), .divisor_in(divisor_in),
        .ack(ack), .res_quot(res_quot), .res_rem(res_rem), .res_ovf(res_ovf), .res_err(res_err),
        .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_quot(div_quot), .div_rem(div_rem), .div_ovf(div_ovf),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    // Divider: busy rises the edge after go, falls LAT edges later unless hung.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            div_busy <= 1'b0;
            mcnt     <= 0;
        end else if (div_go) begin
            div_busy <= 1'b1;
            mcnt     <= LAT;
            if (div_divisor != 0) begin
                div_quot <= 8'(div_dividend / {8'h00, div_divisor});
                div_rem  <= 8'(div_dividend % {8'h00, div_divisor});
                div_ovf  <= (div_dividend / {8'h00, div_divisor}) > 16'd255;
            end
        end else if (div_busy && !hang) begin
            if (mcnt <= 1) div_busy <= 1'b0;
            else mcnt <= mcnt - 1;
        end
    end

    always @(posedge clk) if (div_go) go_cnt <= go_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic [15:0] dvd, input logic [7:0] dsr, input bit tmo);
        exp_t e;
        logic [15:0] q16;
        e.idx = idx;
        e.err = 1'b0;
        if (tmo) begin
            e.q = 8'd0; e.r = 8'd0; e.ovf = 1'b1; e.err = 1'b1;
        end else if (dsr == 8'd0) begin
            e.q = 8'hff; e.r = 8'd0; e.ovf = 1'b1;
        end else begin
            q16   = dvd / {8'h00, dsr};
            e.q   = q16[7:0];
            e.r   = 8'(dvd % {8'h00, dsr});
            e.ovf = (q16 > 16'd255);
        end
        return e;
    endfunction

    task automatic op(input int i, input logic [15:0] dvd, input logic [7:0] dsr, input bit tmo);
        dividend_in[i*16 +: 16] = dvd;
        divisor_in[i*8 +: 8]    = dsr;
        sb.push_back(mk(i, dvd, dsr, tmo));
        req[i] = 1'b1;
    endtask

    task automatic wait_ack(input bit drop, output int waited);
        exp_t       e;
        bit         got;
        logic [1:0] oh;
        got    = 1'b0;
        waited = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            waited++;
            if (ack != 2'b00) got = 1'b1;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            if (!got) begin
                check($sformatf("ack%0d_timeout", e.idx), 32'd0, 32'd1);
            end else begin
                check($sformatf("ack%0d_onehot", e.idx), 32'(ack), 32'(oh));
                check($sformatf("ack%0d_quot", e.idx), 32'(res_quot), 32'(e.q));
                check($sformatf("ack%0d_rem", e.idx), 32'(res_rem), 32'(e.r));
                check($sformatf("ack%0d_ovf", e.idx), 32'(res_ovf), 32'(e.ovf));
                check($sformatf("ack%0d_err", e.idx), 32'(res_err), 32'(e.err));
            end
            if (drop) req[e.idx] = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int g0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_go", 32'(div_go), 32'd0);
        check("rst_quot", 32'(res_quot), 32'd0);
        check("rst_dvd", 32'(div_dividend), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);

        // simultaneous pair straight out of reset: requester 0 first
        arst = 1'b0;
        op(0, 16'd1000, 8'd3, 1'b0);
        op(1, 16'd46845, 8'd200, 1'b0);
        wait_ack(1'b1, lat);
        wait_ack(1'b1, lat);
        @(negedge clk);

        // single request: go pulse, operands, latency
        op(0, 16'd46845, 8'd200, 1'b0);
        @(negedge clk);
        check("go_pulse", 32'(div_go), 32'd1);
        check("go_dvd", 32'(div_dividend), 32'd46845);
        check("go_dsr", 32'(div_divisor), 32'd200);
        check("go_grant", 32'(grant_idx), 32'd0);
        @(negedge clk);
        check("go_oneshot", 32'(div_go), 32'd0);
        wait_ack(1'b1, lat);
        check("lat_min4", 32'(lat + 2 >= 4), 32'd1);
        @(negedge clk);

        // rotation: requester 1 now ahead of 0
        op(1, 16'd1234, 8'd10, 1'b0);
        op(0, 16'd300, 8'd7, 1'b0);
        wait_ack(1'b1, lat);
        wait_ack(1'b1, lat);
        @(negedge clk);

        // zero divisor bypasses the divider
        g0 = go_cnt;
        op(1, 16'd500, 8'd0, 1'b0);
        wait_ack(1'b1, lat);
        check("zdiv_lat", 32'(lat), 32'd1);
        @(negedge clk);
        check("zdiv_nogo", 32'(go_cnt), 32'(g0));

        // hung divider: abort after TMO wait cycles, then a normal op
        hang = 1'b1;
        op(0, 16'd100, 8'd7, 1'b1);
        wait_ack(1'b1, lat);
        check("tmo_lat", 32'(lat), 32'(3 + TMO));
        hang = 1'b0;
        op(1, 16'd46845, 8'd200, 1'b0);
        wait_ack(1'b1, lat);
        @(negedge clk);

        // req held past ack is a second request; dropping it mid-op does not cancel
        op(0, 16'd5000, 8'd50, 1'b0);
        sb.push_back(mk(0, 16'd5000, 8'd50, 1'b0));
        wait_ack(1'b0, lat);
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        wait_ack(1'b1, lat);
        @(negedge clk);

        // reset during WAIT clears everything; pending req is served afterwards
        op(0, 16'd300, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        arst = 1'b1;
        #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_go", 32'(div_go), 32'd0);
        check("mid_rst_quot", 32'(res_quot), 32'd0);
        check("mid_rst_ovf", 32'(res_ovf), 32'd0);
        check("mid_rst_err", 32'(res_err), 32'd0);
        check("mid_rst_dvd", 32'(div_dividend), 32'd0);
        check("mid_rst_dsr", 32'(div_divisor), 32'd0);
        @(negedge clk);
        check("mid_rst_noack", 32'(ack), 32'd0);
        arst = 1'b0;
        wait_ack(1'b1, lat);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
